// File: rtl/clk_gen_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_gen_multi_if
// Description : Control and status bundle for the multi-channel clock/tick
//               generator.
//               master : writes divisors, drives enables and sync clear, and
//                        observes the outputs.
//               slave  : the generator itself.
//   wr_en    : divisor write strobe
//   wr_ch    : target channel of a divisor write
//   wr_div   : new half-period divisor
//   ch_en    : per-channel enable (level)
//   sync_clr : restart all channels in phase
//   clk_out  : per-channel square outputs
//   tick     : per-channel 1-cycle pulse on each clk_out rising edge
//   pend     : per-channel "written divisor not yet applied"
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_gen_multi_if #(
  parameter int N_CH  = 4,
  parameter int CH_W  = 2,
  parameter int CNT_W = 28
);
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic [N_CH-1:0]  ch_en;
  logic             sync_clr;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  pend;

  modport master (
    output wr_en, wr_ch, wr_div, ch_en, sync_clr,
    input  clk_out, tick, pend
  );

  modport slave (
    input  wr_en, wr_ch, wr_div, ch_en, sync_clr,
    output clk_out, tick, pend
  );
endinterface
`default_nettype wire

// File: rtl/clk_gen_multi.sv
`default_nettype none
// ============================================================================
// Module      : clk_gen_multi
// Description : Multi-channel programmable clock/tick generator. Each channel
//               produces a 50%-duty square wave with frequency
//               f = f_clk / (2*(div+1)) and a 1-cycle tick at every rising
//               edge. Divisors are written at run time and take effect only
//               at a full-period boundary (high->low toggle), on disable, or
//               on sync clear, so the outputs never glitch.
//   clk_50M : system clock
//   rst_n   : asynchronous, active-low reset
//   bus     : clk_gen_multi_if slave (write port, enables, sync clear,
//             clk_out / tick / pend outputs; all outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module clk_gen_multi #(
  parameter int          N_CH    = 4,
  parameter int          CH_W    = 2,
  parameter int          CNT_W   = 28,
  parameter int unsigned DEF_DIV = 24_999_999
) (
  input  logic           clk_50M,
  input  logic           rst_n,
  clk_gen_multi_if.slave bus
);

  localparam logic [CNT_W-1:0] C_DEF_DIV = CNT_W'(DEF_DIV);

  logic [N_CH-1:0] w_clk_out;
  logic [N_CH-1:0] w_tick;
  logic [N_CH-1:0] w_pend;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] C_CH_IDX = CH_W'(i);

    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] div_act_q,  div_act_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             clk_q,      clk_d;
    logic             tick_q,     tick_d;
    logic             pend_q,     pend_d;
    logic             w_wrap;
    logic             w_wr_hit;
    logic             w_apply;

    // Counter terminal value: cnt stops at div_act and wraps to 0, so even
    // the all-ones divisor never overflows the counter.
    assign w_wrap   = (cnt_q == div_act_q);
    // Channel indices beyond N_CH-1 match no channel, so such writes vanish.
    assign w_wr_hit = bus.wr_en && (bus.wr_ch == C_CH_IDX);

    always_comb begin
      cnt_d   = cnt_q;
      clk_d   = clk_q;
      tick_d  = 1'b0;
      w_apply = 1'b0;
      if (bus.sync_clr || !bus.ch_en[i]) begin
        // Stopped or restarted: phase is reset, so a pending divisor can be
        // applied right away without shortening any visible period.
        cnt_d   = '0;
        clk_d   = 1'b0;
        w_apply = pend_q;
      end else if (w_wrap) begin
        cnt_d   = '0;
        clk_d   = ~clk_q;
        tick_d  = ~clk_q;
        // Only the high->low toggle closes a full period.
        w_apply = pend_q && clk_q;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
      end

      // A write coinciding with an apply: the active divisor takes the old
      // pending value and the new write stays pending.
      div_act_d  = w_apply  ? div_pend_q : div_act_q;
      div_pend_d = w_wr_hit ? bus.wr_div : div_pend_q;
      pend_d     = w_wr_hit | (pend_q & ~w_apply);
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q      <= '0;
        div_act_q  <= C_DEF_DIV;
        div_pend_q <= C_DEF_DIV;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
        pend_q     <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        div_act_q  <= div_act_d;
        div_pend_q <= div_pend_d;
        clk_q      <= clk_d;
        tick_q     <= tick_d;
        pend_q     <= pend_d;
      end
    end

    assign w_clk_out[i] = clk_q;
    assign w_tick[i]    = tick_q;
    assign w_pend[i]    = pend_q;
  end

  assign bus.clk_out = w_clk_out;
  assign bus.tick    = w_tick;
  assign bus.pend    = w_pend;

endmodule
`default_nettype wire
